// File: rtl/cavlc_block_sched.sv
// CAVLC block sequencer: captures a 4x4 coefficient block, scans it in reverse zig-zag
// order, then presents the block header followed by one {level, run_before} beat per nonzero.
module cavlc_block_sched #(
  parameter int COEF_W = 15
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  blk_valid,
  output logic                  blk_ready,
  input  logic [16*COEF_W-1:0]  blk_data,
  output logic                  hdr_valid,
  input  logic                  hdr_ready,
  output logic [4:0]            total_coeff,
  output logic [1:0]            trailing_ones,
  output logic [3:0]            total_zeros,
  output logic                  coef_valid,
  input  logic                  coef_ready,
  output logic [COEF_W-1:0]     coef_level,
  output logic [3:0]            coef_run,
  output logic                  coef_last,
  output logic                  busy
);

  typedef enum logic [1:0] {IDLE, SCAN, HDR, EMIT} state_t;

  state_t                   state;
  logic signed [COEF_W-1:0] coef_q [16];
  logic signed [COEF_W-1:0] lev_q  [16];
  logic [3:0]               run_q  [16];

  logic [3:0]               pos;
  logic [4:0]               tc;
  logic [1:0]               t1;
  logic                     t1_done;
  logic [3:0]               tz;
  logic [3:0]               beat;

  logic [4:0]               tc_nxt;
  logic [1:0]               t1_nxt;
  logic                     t1_done_nxt;
  logic [3:0]               tz_nxt;
  logic signed [COEF_W-1:0] cur;
  logic [3:0]               last_idx;

  function automatic logic [3:0] zz_raster(input logic [3:0] p);
    case (p)
      4'd0:    zz_raster = 4'd0;
      4'd1:    zz_raster = 4'd1;
      4'd2:    zz_raster = 4'd4;
      4'd3:    zz_raster = 4'd8;
      4'd4:    zz_raster = 4'd5;
      4'd5:    zz_raster = 4'd2;
      4'd6:    zz_raster = 4'd3;
      4'd7:    zz_raster = 4'd6;
      4'd8:    zz_raster = 4'd9;
      4'd9:    zz_raster = 4'd12;
      4'd10:   zz_raster = 4'd13;
      4'd11:   zz_raster = 4'd10;
      4'd12:   zz_raster = 4'd7;
      4'd13:   zz_raster = 4'd11;
      4'd14:   zz_raster = 4'd14;
      default: zz_raster = 4'd15;
    endcase
  endfunction

  function automatic logic is_unit(input logic signed [COEF_W-1:0] v);
    is_unit = (v == {{(COEF_W-1){1'b0}}, 1'b1}) || (v == {COEF_W{1'b1}});
  endfunction

  assign cur       = coef_q[zz_raster(pos)];
  // tc counts entries, so the newest entry sits one below it (16 wraps to index 15)
  assign last_idx  = tc[3:0] - 4'd1;
  assign blk_ready = (state == IDLE) && !rst;
  assign busy      = (state != IDLE);

  always_comb begin
    tc_nxt      = tc;
    t1_nxt      = t1;
    t1_done_nxt = t1_done;
    tz_nxt      = tz;
    if (cur != '0) begin
      tc_nxt = tc + 5'd1;
      if (!t1_done) begin
        if (!is_unit(cur))
          t1_done_nxt = 1'b1;
        else if (t1 != 2'd3)
          t1_nxt = t1 + 2'd1;
      end
    end else if (tc != 5'd0) begin
      tz_nxt = tz + 4'd1;
    end
  end

  // Block capture and scan list; zeros extend the run of the most recent nonzero entry
  always_ff @(posedge clk) begin
    if (state == IDLE && blk_valid) begin
      for (int k = 0; k < 16; k++)
        coef_q[k] <= blk_data[k*COEF_W +: COEF_W];
    end
    if (state == SCAN) begin
      if (cur != '0) begin
        lev_q[tc[3:0]] <= cur;
        run_q[tc[3:0]] <= 4'd0;
      end else if (tc != 5'd0) begin
        run_q[last_idx] <= run_q[last_idx] + 4'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      pos           <= 4'd0;
      tc            <= 5'd0;
      t1            <= 2'd0;
      t1_done       <= 1'b0;
      tz            <= 4'd0;
      beat          <= 4'd0;
      hdr_valid     <= 1'b0;
      total_coeff   <= 5'd0;
      trailing_ones <= 2'd0;
      total_zeros   <= 4'd0;
      coef_valid    <= 1'b0;
      coef_level    <= '0;
      coef_run      <= 4'd0;
      coef_last     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (blk_valid) begin
            state   <= SCAN;
            pos     <= 4'd15;
            tc      <= 5'd0;
            t1      <= 2'd0;
            t1_done <= 1'b0;
            tz      <= 4'd0;
          end
        end
        SCAN: begin
          tc      <= tc_nxt;
          t1      <= t1_nxt;
          t1_done <= t1_done_nxt;
          tz      <= tz_nxt;
          if (pos == 4'd0) begin
            state         <= HDR;
            hdr_valid     <= 1'b1;
            total_coeff   <= tc_nxt;
            trailing_ones <= t1_nxt;
            total_zeros   <= tz_nxt;
          end else begin
            pos <= pos - 4'd1;
          end
        end
        HDR: begin
          if (hdr_ready) begin
            hdr_valid <= 1'b0;
            if (tc == 5'd0) begin
              state <= IDLE;
            end else begin
              state      <= EMIT;
              coef_valid <= 1'b1;
              coef_level <= lev_q[0];
              coef_run   <= run_q[0];
              coef_last  <= (tc == 5'd1);
              beat       <= 4'd1;
            end
          end
        end
        EMIT: begin
          if (coef_ready) begin
            if (coef_last) begin
              coef_valid <= 1'b0;
              state      <= IDLE;
            end else begin
              coef_level <= lev_q[beat];
              coef_run   <= run_q[beat];
              coef_last  <= (beat == last_idx);
              beat       <= beat + 4'd1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cavlc_block_sched.sv
// Bench for cavlc_block_sched: directed and random blocks against a list-based reference
// model, with tied, random and alternating ready patterns plus a mid-EMIT reset.
module tb_cavlc_block_sched;
  localparam int COEF_W = 15;
  localparam int ZZ [16] = '{0, 1, 4, 8, 5, 2, 3, 6, 9, 12, 13, 10, 7, 11, 14, 15};

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 blk_valid;
  logic                 blk_ready;
  logic [16*COEF_W-1:0] blk_data;
  logic                 hdr_valid;
  logic                 hdr_ready;
  logic [4:0]           total_coeff;
  logic [1:0]           trailing_ones;
  logic [3:0]           total_zeros;
  logic                 coef_valid;
  logic                 coef_ready;
  logic [COEF_W-1:0]    coef_level;
  logic [3:0]           coef_run;
  logic                 coef_last;
  logic                 busy;

  always #5 clk = ~clk;

  cavlc_block_sched #(.COEF_W(COEF_W)) dut (
    .clk(clk), .rst(rst),
    .blk_valid(blk_valid), .blk_ready(blk_ready), .blk_data(blk_data),
    .hdr_valid(hdr_valid), .hdr_ready(hdr_ready),
    .total_coeff(total_coeff), .trailing_ones(trailing_ones), .total_zeros(total_zeros),
    .coef_valid(coef_valid), .coef_ready(coef_ready),
    .coef_level(coef_level), .coef_run(coef_run), .coef_last(coef_last),
    .busy(busy)
  );

  int n_cmp = 0;
  int n_err = 0;
  int mode;
  bit tog;

  logic signed [COEF_W-1:0] blk [16];
  int                       exp_tc, exp_t1, exp_tz;
  logic [COEF_W-1:0]        exp_lev [16];
  int                       exp_run [16];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference: list the zig-zag positions of nonzeros from high to low and derive everything from them
  task automatic model();
    int p[$];
    int ones;
    p.delete();
    for (int z = 15; z >= 0; z--)
      if (blk[ZZ[z]] != 0) p.push_back(z);
    exp_tc = p.size();
    exp_tz = (exp_tc == 0) ? 0 : p[0] + 1 - exp_tc;
    for (int k = 0; k < exp_tc; k++) begin
      exp_lev[k] = blk[ZZ[p[k]]];
      exp_run[k] = (k == exp_tc - 1) ? p[k] : p[k] - p[k+1] - 1;
    end
    ones = 0;
    while (ones < exp_tc && (blk[ZZ[p[ones]]] == 1 || blk[ZZ[p[ones]]] == -1)) ones++;
    exp_t1 = (ones > 3) ? 3 : ones;
  endtask

  function automatic bit pick();
    if (mode == 0) return 1'b1;
    if (mode == 2) begin
      tog = ~tog;
      return tog;
    end
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic send();
    int cyc = 0;
    while (!blk_ready && cyc < 50) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("blk_ready", blk_ready, 1);
    for (int k = 0; k < 16; k++) blk_data[k*COEF_W +: COEF_W] = blk[k];
    blk_valid = 1'b1;
    @(posedge clk); #1;
    blk_valid = 1'b0;
    for (int k = 0; k < 16; k++) blk_data[k*COEF_W +: COEF_W] = COEF_W'($urandom);
  endtask

  task automatic do_block(input int m);
    int  cyc;
    int  n;
    bit  hs;
    mode = m;
    tog = 1'b0;
    hdr_ready = (mode == 0);
    coef_ready = (mode == 0);
    model();
    send();
    chk("busy_scan", busy, 1);
    repeat (15) begin @(posedge clk); #1; end
    chk("hdr_early", hdr_valid, 0);
    @(posedge clk); #1;
    chk("hdr_lat", hdr_valid, 1);
    chk("tc", total_coeff, exp_tc);
    chk("t1", trailing_ones, exp_t1);
    chk("tz", total_zeros, exp_tz);
    chk("coef_idle", coef_valid, 0);
    hs = 1'b0;
    cyc = 0;
    while (!hs && cyc < 40) begin
      chk("hdr_hold", hdr_valid, 1);
      chk("tc_hold", total_coeff, exp_tc);
      hdr_ready = pick();
      hs = hdr_valid && hdr_ready;
      @(posedge clk); #1;
      cyc++;
    end
    chk("hdr_hs", hs, 1);
    hdr_ready = (mode == 0);
    chk("hdr_clr", hdr_valid, 0);
    if (exp_tc == 0) begin
      chk("zero_nocoef", coef_valid, 0);
      chk("zero_ready", blk_ready, 1);
    end else begin
      n = 0;
      cyc = 0;
      while (n < exp_tc && cyc < 200) begin
        chk("coef_vld", coef_valid, 1);
        chk("lev", coef_level, exp_lev[n]);
        chk("run", coef_run, exp_run[n]);
        chk("last", coef_last, (n == exp_tc - 1));
        coef_ready = pick();
        if (coef_valid && coef_ready) n++;
        @(posedge clk); #1;
        cyc++;
      end
      chk("beat_count", n, exp_tc);
      coef_ready = (mode == 0);
      chk("emit_done", coef_valid, 0);
      chk("idle_ready", blk_ready, 1);
      chk("idle_busy", busy, 0);
    end
  endtask

  task automatic gen_rand();
    int dens = $urandom_range(0, 16);
    int v;
    for (int k = 0; k < 16; k++) begin
      blk[k] = '0;
      if ($urandom_range(0, 15) < dens) begin
        case ($urandom_range(0, 4))
          0: blk[k] = COEF_W'(1);
          1: blk[k] = COEF_W'(-1);
          2: begin v = $urandom_range(2, 40); blk[k] = COEF_W'(v); end
          3: begin v = $urandom_range(2, 40); blk[k] = COEF_W'(-v); end
          default: blk[k] = COEF_W'($urandom);
        endcase
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    int cyc;
    rst = 1'b1;
    blk_valid = 1'b0;
    hdr_ready = 1'b0;
    coef_ready = 1'b0;
    blk_data = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_blk_ready", blk_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_hdr_valid", hdr_valid, 0);
    chk("rst_coef_valid", coef_valid, 0);
    chk("rst_tc", total_coeff, 0);
    chk("rst_level", coef_level, 0);
    chk("rst_last", coef_last, 0);
    rst = 1'b0;
    #1;
    chk("rst_release_ready", blk_ready, 1);

    blk = '{3, 0, 8, 0, 61, 0, 56, 50, 20, 0, 1, 46, 0, 52, 0, 0};
    do_block(1);
    blk = '{0, 0, 8, 0, 61, 0, 56, 0, 20, 0, 1, 46, 0, 0, 0, 0};
    do_block(0);
    blk = '{5, 1, 0, 0, 15'h7FFF, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0};
    do_block(2);
    blk = '{1, 1, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0};
    do_block(0);
    blk = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    do_block(1);
    blk = '{3, 0, 8, 0, 61, 0, 56, 50, 20, 0, 1, 46, 0, 52, 0, 0};
    do_block(2);
    for (int k = 0; k < 16; k++) blk[k] = COEF_W'(k + 100);
    do_block(1);

    // Reset while a beat is stalled in EMIT
    blk = '{3, 0, 8, 0, 61, 0, 56, 50, 20, 0, 1, 46, 0, 52, 0, 0};
    hdr_ready = 1'b1;
    coef_ready = 1'b0;
    send();
    cyc = 0;
    while (!coef_valid && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("abort_first_beat", coef_level, 46);
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    chk("abort_coef_valid", coef_valid, 0);
    chk("abort_hdr_valid", hdr_valid, 0);
    chk("abort_busy", busy, 0);
    chk("abort_level", coef_level, 0);
    chk("abort_tc", total_coeff, 0);
    chk("abort_blk_ready", blk_ready, 0);
    rst = 1'b0;
    hdr_ready = 1'b0;
    coef_ready = 1'b1;
    #1;
    chk("abort_ready_back", blk_ready, 1);
    repeat (3) begin
      @(posedge clk); #1;
      chk("abort_no_beats", coef_valid, 0);
    end
    blk = '{0, 0, 8, 0, 61, 0, 56, 0, 20, 0, 1, 46, 0, 0, 0, 0};
    do_block(1);

    for (int i = 0; i < 40; i++) begin
      gen_rand();
      do_block($urandom_range(0, 2));
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
